sysid_info_regs: RTL

//  Parametrised system-identification slave: Avalon-MM register file returning build constants
//  (system ID, build timestamp, version), a software scratch word and a free-running uptime counter.

---
 rtl/sysid_info_regs_pkg.sv | 20 ++
 rtl/sysid_info_regs_if.sv | 27 ++
 rtl/sysid_info_regs_uptime.sv | 64 ++++++
 rtl/sysid_info_regs.sv | 104 ++++++++++
 4 files changed

// File: rtl/sysid_info_regs_pkg.sv
// sysid_info_regs: shared word map and CTRL/STATUS bit layout.
// Imported by the interface, the uptime counter and the top level.
package sysid_pkg;

  localparam logic [2:0] SYSID_A   = 3'd0;
  localparam logic [2:0] TSTAMP_A  = 3'd1;
  localparam logic [2:0] VERSION_A = 3'd2;
  localparam logic [2:0] SCRATCH_A = 3'd3;
  localparam logic [2:0] UPLO_A    = 3'd4;
  localparam logic [2:0] UPHI_A    = 3'd5;
  localparam logic [2:0] CTRL_A    = 3'd6;
  localparam logic [2:0] STATUS_A  = 3'd7;

  localparam int CTRL_EN_B   = 0;
  localparam int CTRL_CLR_B  = 1;
  localparam int STATUS_SV_B = 0;

  localparam logic CTRL_EN_RST = 1'b1;

endpackage

// File: rtl/sysid_info_regs_if.sv
// sysid_info_regs: Avalon-MM slave bus bundle.
// The master drives strobes, the slave returns registered read data.
interface sysid_info_regs_if #(
  parameter int ADDR_W = 3
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_info_regs_uptime.sv
// sysid_info_regs: prescaled free-running uptime counter
// with EN/CLR control and an atomic high-word snapshot.
module sysid_uptime_counter
  import sysid_pkg::*;
#(
  parameter int CNT_W    = 64,
  parameter int TICK_DIV = 50
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_we,
  input  logic             ctrl_en,
  input  logic             ctrl_clr,
  input  logic             snap_req,
  input  logic             snap_ack,
  output logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [31:0]      snap,
  output logic             snap_valid
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic          clr;

  assign tick = en && (pre == PW'(TICK_DIV - 1));
  assign clr  = ctrl_we && ctrl_clr;

  // prescaler and counter; a clear beats a coincident tick
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre <= '0;
      cnt <= '0;
      en  <= CTRL_EN_RST;
    end else begin
      if (ctrl_we) en <= ctrl_en;
      if (clr) begin
        pre <= '0;
        cnt <= '0;
      end else if (tick) begin
        pre <= '0;
        cnt <= cnt + CNT_W'(1);
      end else if (en) begin
        pre <= pre + PW'(1);
      end
    end
  end

  // high word captured with the same edge that returns the low word
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      snap       <= '0;
      snap_valid <= 1'b0;
    end else if (snap_req) begin
      snap       <= 32'(cnt[CNT_W-1:32]);
      snap_valid <= 1'b1;
    end else if (snap_ack || clr) begin
      snap_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sysid_info_regs.sv
// sysid_info_regs: build-identification register file with
// scratch word, uptime counter and one-cycle registered reads.
module sysid_info_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h6066_6D7A,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          ADDR_W    = 3,
  parameter int          CNT_W     = 64,
  parameter int          TICK_DIV  = 50
) (
  input logic               clock,
  input logic               reset_n,
  sysid_info_regs_if.slave  bus
);

  logic [31:0]      addr;
  logic [2:0]       word;
  logic             mapped;
  logic             wr_acc;
  logic             scratch_we;
  logic             ctrl_we;
  logic             snap_req;
  logic             snap_ack;
  logic [31:0]      scratch;
  logic [31:0]      rd_mux;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             en;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      snap;
  logic             snap_valid;

  assign addr       = 32'(bus.address[ADDR_W-1:0]);
  assign word       = addr[2:0];
  assign mapped     = addr < 32'd8;
  assign wr_acc     = bus.write && !bus.read && mapped;
  assign scratch_we = wr_acc && word == SCRATCH_A;
  assign ctrl_we    = wr_acc && word == CTRL_A;
  assign snap_req   = bus.read && mapped && word == UPLO_A;
  assign snap_ack   = bus.read && mapped && word == UPHI_A;

  sysid_uptime_counter #(
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV)
  ) u_up (
    .clock      (clock),
    .reset_n    (reset_n),
    .ctrl_we    (ctrl_we),
    .ctrl_en    (bus.writedata[CTRL_EN_B]),
    .ctrl_clr   (bus.writedata[CTRL_CLR_B]),
    .snap_req   (snap_req),
    .snap_ack   (snap_ack),
    .en         (en),
    .cnt        (cnt),
    .snap       (snap),
    .snap_valid (snap_valid)
  );

  // software scratch word with per-byte lane enables
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (scratch_we) begin
      for (int i = 0; i < 4; i++)
        if (bus.byteenable[i])
          scratch[8*i +: 8] <= bus.writedata[8*i +: 8];
    end
  end

  // read mux; unmapped words return zero
  always_comb begin
    rd_mux = '0;
    if (mapped) begin
      unique case (1'b1)
        word == SYSID_A:   rd_mux = SYSTEM_ID;
        word == TSTAMP_A:  rd_mux = TIMESTAMP;
        word == VERSION_A: rd_mux = VERSION;
        word == SCRATCH_A: rd_mux = scratch;
        word == UPLO_A:    rd_mux = cnt[31:0];
        word == UPHI_A:    rd_mux = snap;
        word == CTRL_A:    rd_mux = {31'd0, en};
        word == STATUS_A:  rd_mux = {31'd0, snap_valid};
        default:           rd_mux = '0;
      endcase
    end
  end

  // registered read return; data held until the next read
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= bus.read;
      if (bus.read) rdata <= rd_mux;
    end
  end

  assign bus.readdata      = rdata;
  assign bus.readdatavalid = rvalid;

endmodule
